// File: rtl/mult_pkg.sv
// Shared constants and operand/product types for the pipelined DSP48 multiplier.
package mult_pkg;

  localparam int unsigned MULT_W       = 16;
  localparam int unsigned MULT_LATENCY = 2;

  typedef logic [MULT_W-1:0]   mult_op_t;
  typedef logic [2*MULT_W-1:0] mult_prod_t;

endpackage : mult_pkg

// File: rtl/valid_delay_line.sv
// DEPTH-stage shift register for a 1-bit valid flag, cleared asynchronously.
module valid_delay_line #(
  parameter int unsigned DEPTH = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic valid_in,
  output logic valid_out
);

  logic [DEPTH-1:0] stage_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stage_q <= '0;
    end else begin
      stage_q[0] <= valid_in;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign valid_out = stage_q[DEPTH-1];

endmodule : valid_delay_line

// File: rtl/multiplier_dsp48.sv
// Two-stage unsigned multiplier laid out for DSP48 inference (AREG/BREG=1, MREG=0, PREG=1).
module multiplier_dsp48
  import mult_pkg::*;
#(
  parameter int unsigned W       = MULT_W,
  parameter int unsigned LATENCY = MULT_LATENCY
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [W-1:0]     in0,
  input  logic [W-1:0]     in1,
  input  logic             valid_in,
  output logic [2*W-1:0]   out,
  output logic             valid_out
);

  generate
    if (LATENCY != 2) begin : g_bad_latency
      $error("multiplier_dsp48: LATENCY must be 2");
    end
    if (W == 0 || W > 18) begin : g_bad_width
      $error("multiplier_dsp48: W must be in 1..18");
    end
  endgenerate

  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [2*W-1:0] p_q;

  // Operands widened before the multiply so the full 2*W product is kept.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_q <= '0;
      b_q <= '0;
      p_q <= '0;
    end else begin
      a_q <= in0;
      b_q <= in1;
      p_q <= (2*W)'(a_q) * (2*W)'(b_q);
    end
  end

  assign out = p_q;

  valid_delay_line #(
    .DEPTH (LATENCY)
  ) u_valid_delay (
    .clock     (clock),
    .reset_n   (reset_n),
    .valid_in  (valid_in),
    .valid_out (valid_out)
  );

endmodule : multiplier_dsp48

// File: tb/tb_multiplier_dsp48.sv
// Scoreboard bench for multiplier_dsp48: directed steps plus random sparse traffic.
module tb_multiplier_dsp48;
  import mult_pkg::*;

  localparam int unsigned W = MULT_W;

  logic           clock = 1'b0;
  logic           reset_n = 1'b0;
  logic [W-1:0]   in0 = '0;
  logic [W-1:0]   in1 = '0;
  logic           valid_in = 1'b0;
  logic [2*W-1:0] out;
  logic           valid_out;

  typedef struct {
    longint unsigned prod;
    int              due;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cycle = 0;
  int   in_pulses = 0;
  int   out_pulses = 0;

  multiplier_dsp48 #(
    .W       (W),
    .LATENCY (2)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in0       (in0),
    .in1       (in1),
    .valid_in  (valid_in),
    .out       (out),
    .valid_out (valid_out)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cycle++;

  task automatic check(input string tag, input longint unsigned obs, input longint unsigned exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; the next rising edge samples them.
  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    @(negedge clock);
    in0 = a;
    in1 = b;
    valid_in = v;
    if (v && reset_n) begin
      e.prod = longint'(a) * longint'(b);
      e.due  = cycle + 2;
      sb.push_back(e);
      in_pulses++;
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (!reset_n) begin
      check("reset_out", out, 0);
      check("reset_valid", valid_out, 0);
    end else if (valid_out) begin
      out_pulses++;
      if (sb.size() == 0) begin
        check("spurious_valid", valid_out, 0);
      end else begin
        e = sb.pop_front();
        check("product", out, e.prod);
        check("latency", cycle, e.due);
      end
    end else if (sb.size() > 0 && sb[0].due <= cycle) begin
      check("missing_valid", valid_out, 1);
      void'(sb.pop_front());
    end
  end

  initial begin
    int n;
    int guard;
    logic v;

    // Reset held with live inputs: outputs must stay cleared.
    valid_in = 1'b1;
    in0 = 5;
    in1 = 7;
    repeat (4) @(negedge clock);
    valid_in = 1'b0;
    in0 = '0;
    in1 = '0;
    #2 reset_n = 1'b1;
    repeat (2) drive(0, 0, 0);

    // Single op then idle.
    drive(1, 3, 4);
    repeat (4) drive(0, 0, 0);

    // Maximum operands.
    drive(1, '1, '1);
    repeat (3) drive(0, 0, 0);

    // Back-to-back stream and the 1*x / 0*x boundaries.
    drive(1, 1, 16'hFFFF);
    drive(1, 2, 2);
    drive(1, 16'hFFFF, 1);
    drive(1, 0, 123);
    repeat (4) drive(0, 0, 0);

    // Random sparse traffic.
    in_pulses = 0;
    out_pulses = 0;
    n = 0;
    guard = 0;
    while (n < 50 && guard < 5000) begin
      v = ($urandom_range(9) == 0);
      drive(v, W'($urandom_range(65535, 1)), W'($urandom_range(65535, 1)));
      if (v) n++;
      guard++;
    end
    guard = 0;
    while (sb.size() > 0 && guard < 10) begin
      drive(0, 0, 0);
      guard++;
    end
    drive(0, 0, 0);
    check("drain_empty", sb.size(), 0);
    check("pulse_count", out_pulses, in_pulses);

    // Reset one cycle after a valid input: the result must never appear.
    drive(1, 6, 7);
    @(negedge clock);
    valid_in = 1'b0;
    #2 reset_n = 1'b0;
    sb.delete();
    #1;
    check("midflight_out", out, 0);
    check("midflight_valid", valid_out, 0);
    repeat (3) @(negedge clock);
    #2 reset_n = 1'b1;
    repeat (5) drive(0, 0, 0);

    // Reset while a result is being presented: valid_out drops at once.
    drive(1, 9, 9);
    drive(0, 0, 0);
    @(negedge clock);
    #2 reset_n = 1'b0;
    sb.delete();
    #1;
    check("async_drop_valid", valid_out, 0);
    check("async_drop_out", out, 0);
    repeat (2) @(negedge clock);
    #2 reset_n = 1'b1;
    repeat (4) drive(0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_multiplier_dsp48

// File: doc/multiplier_dsp48.md
Name: multiplier_dsp48

Overview:
- Fully pipelined unsigned integer multiplier, structured to map onto one DSP48 slice: input register stage, then product register stage.
- Sits in the datapath as a fixed-latency functional unit.
- Accepts a new operand pair every cycle.
- A valid bit travels alongside the data to qualify the result.

Parameters:
- W, 16, operand width in bits; product width is 2*W. Supported range 1..18 so a single DSP48 multiplier suffices.
- LATENCY, 2, cycles from the sampling edge to a registered result. Fixed at 2; any other value is a synthesis-time error.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- in0  input  W  unsigned multiplicand.
- in1  input  W  unsigned multiplier.
- valid_in  input  1  qualifies in0/in1 in this cycle.
- out  output  2*W  unsigned product, registered.
- valid_out  output  1  qualifies out.

Behaviour:
- Reset:
  - The reset_n low level asynchronously clears all pipeline registers: a_q, b_q, v1_q, p_q, v2_q.
  - While reset_n is low: out = 0, valid_out = 0.
  - Release is synchronised by the surrounding reset logic; the block needs no extra startup cycles after release.
- Stage 1, edge k:
  - a_q <= in0; b_q <= in1; v1_q <= valid_in.
  - Inputs register unconditionally every cycle; there is no enable.
- Stage 2, edge k+1:
  - p_q <= a_q * b_q, a full 2*W-bit unsigned product with no truncation and no overflow possible.
  - v2_q <= v1_q.
- Outputs: out = p_q and valid_out = v2_q, driven directly from registers with no combinational path from inputs.
- Latency: operands sampled at edge k appear on out after edge k+1, and are stable for one cycle, until edge k+2. valid_out equals valid_in delayed by exactly 2 edges.
- Throughput: one result per cycle. Back-to-back valid inputs produce back-to-back valid outputs in the same order.
- No backpressure: no ready signal exists, and the consumer must accept every result when valid_out = 1.
- Invalid cycles: the data path still computes. out then holds the product of whatever was on in0/in1 and is don't-care. Consumers must gate on valid_out.
- Boundaries:
  - 0 * x = 0.
  - (2^W-1)*(2^W-1) = 2^(2W) - 2^(W+1) + 1; for W=16 this is 0xFFFE0001.
  - 1 * x = x.
- Reset mid-operation: in-flight results are discarded and valid_out drops immediately (asynchronously). No spurious valid follows reset release.
- Implementation style: plain `*` operator, with registers arranged so the tools infer AREG/BREG=1, MREG=0, PREG=1. No vendor primitive instantiation is required.

Decomposition:
- Shared package mult_pkg:
  - localparam MULT_W = 16.
  - localparam MULT_LATENCY = 2.
  - typedef logic [MULT_W-1:0] mult_op_t.
  - typedef logic [2*MULT_W-1:0] mult_prod_t.
- One natural sub-module: valid_delay_line, a parameterised DEPTH shift register of 1-bit valid with async active-low clear. Instantiate it with DEPTH = LATENCY.
- The data path stays inline.

Test Plan:
- Reset: hold reset_n = 0 with valid_in = 1, in0 = 5, in1 = 7 -> out = 0 and valid_out = 0 throughout. After release, the first valid_out rises exactly 2 edges after the first sampling edge.
- Single op: valid_in = 1, in0 = 3, in1 = 4 for one cycle, otherwise 0 -> after 2 edges out = 12 and valid_out = 1 for exactly one cycle, then valid_out = 0.
- Max operands: in0 = in1 = 65535 -> out = 0xFFFE0001 (4294836225), with no truncation.
- Back-to-back: valid pairs (1,65535), (2,2), (65535,1), (0,123) on consecutive cycles -> outputs 65535, 4, 65535, 0 on 4 consecutive cycles, in order, with valid_out high throughout.
- Random: 50 results; valid_in asserted with probability 1/10; operands uniform in 1..65535 -> every cycle with valid_out = 1 shows out equal to the product of the pair sampled 2 edges earlier. The count of valid_out pulses equals the count of valid_in pulses.
- Reset mid-flight: assert reset_n = 0 one cycle after a valid input -> valid_out never pulses for that input, and out = 0 during reset.
